// File: rtl/repeat_n_upsample_if.sv
// AXI-Stream style handshake bundle shared by the sink and source sides
// of repeat_n_upsample.
interface repeat_n_upsample_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/repeat_n_upsample.sv
// Sample-repeat / zero-stuff interpolator: every accepted input beat is
// emitted max(n,1) times, with the factor latched at the start of each packet.
//
// state  | meaning
// EMPTY  | no held sample, sink ready
// REPEAT | held sample being emitted, repetition rep_q in 1..n_act_q
module repeat_n_upsample #(
    parameter int  WIDTH = 32,
    parameter int  MAX_N = 65535,
    localparam int NW    = $clog2(MAX_N + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NW-1:0]         n,
    input  logic                  zero_stuff,
    repeat_n_upsample_if.slave    i_axis,
    repeat_n_upsample_if.master   o_axis
);
    localparam logic [NW-1:0] ONE     = NW'(1);
    localparam logic [NW-1:0] MAX_N_W = NW'(MAX_N);

    typedef enum logic {EMPTY, REPEAT} state_t;

    state_t           state_q;
    logic [NW-1:0]    rep_q;
    logic [NW-1:0]    n_act_q;
    logic             zs_act_q;
    logic             sop_q;
    logic [WIDTH-1:0] hold_data_q;
    logic             hold_last_q;
    logic [WIDTH-1:0] tdata_q;
    logic             tlast_q;
    logic             tvalid_q;

    logic [NW-1:0]    n_clamp;
    logic [NW-1:0]    n_act_d;
    logic             zs_act_d;
    logic [NW-1:0]    rep_d;
    logic             last_rep;
    logic             in_ready;
    logic             accept;
    logic             retire;
    logic             advance;

    // A factor above MAX_N is clamped so rep_q can never run past MAX_N.
    generate
        if ((2 ** NW) - 1 > MAX_N) begin : g_clamp
            assign n_clamp = (n > MAX_N_W) ? MAX_N_W : n;
        end else begin : g_noclamp
            assign n_clamp = n;
        end
    endgenerate

    always_comb begin
        last_rep = (rep_q >= n_act_q);
        in_ready = reset_n && ((state_q == EMPTY) || (last_rep && o_axis.tready));
        accept   = in_ready && i_axis.tvalid;
        retire   = (state_q == REPEAT) && o_axis.tready && last_rep;
        advance  = (state_q == REPEAT) && o_axis.tready && !last_rep;
        n_act_d  = sop_q ? n_clamp : n_act_q;
        zs_act_d = sop_q ? zero_stuff : zs_act_q;
        rep_d    = rep_q + ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            rep_q       <= ONE;
            n_act_q     <= ONE;
            zs_act_q    <= 1'b0;
            sop_q       <= 1'b1;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
        end else if (accept) begin
            // Covers both a load from EMPTY and the same-cycle reload on retire.
            state_q     <= REPEAT;
            rep_q       <= ONE;
            n_act_q     <= n_act_d;
            zs_act_q    <= zs_act_d;
            sop_q       <= i_axis.tlast;
            hold_data_q <= i_axis.tdata;
            hold_last_q <= i_axis.tlast;
            tdata_q     <= i_axis.tdata;
            tlast_q     <= i_axis.tlast && (n_act_d <= ONE);
            tvalid_q    <= 1'b1;
        end else if (retire) begin
            state_q  <= EMPTY;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (advance) begin
            rep_q   <= rep_d;
            tdata_q <= zs_act_q ? '0 : hold_data_q;
            tlast_q <= hold_last_q && (rep_d >= n_act_q);
        end
    end

    assign i_axis.tready = in_ready;
    assign o_axis.tdata  = tdata_q;
    assign o_axis.tlast  = tlast_q;
    assign o_axis.tvalid = tvalid_q;
endmodule

// File: doc/repeat_n_upsample.md
REPEAT_N_UPSAMPLE -- requirements
Module: repeat_n_upsample

Interface
REQ-001: Parameter WIDTH, default 32, sample width in bits.
REQ-002: Parameter MAX_N, default 65535, largest supported interpolation factor; NW = $clog2(MAX_N+1).
REQ-003: clk  input  1  single clock; all logic rising-edge.
REQ-004: reset_n  input  1  synchronous, active-low reset.
REQ-005: n  input  NW  interpolation factor; 0 and 1 both mean pass-through.
REQ-006: zero_stuff  input  1  0 = hold (repeat sample), 1 = insert zeros after the sample.
REQ-007: i_tdata/i_tlast/i_tvalid  input  WIDTH/1/1  AXI-Stream sink data, end-of-packet, valid.
REQ-008: i_tready  output  1  sink ready.
REQ-009: o_tdata/o_tlast/o_tvalid  output  WIDTH/1/1  AXI-Stream source data, end-of-packet, valid.
REQ-010: o_tready  input  1  source ready.

Function
REQ-011: Each accepted input beat SHALL produce exactly max(n_act,1) output beats, where n_act is the latched factor.
REQ-012: n and zero_stuff SHALL be latched into n_act/zs_act only on acceptance of the first beat of an input packet (first beat after reset or after an accepted i_tlast); changes mid-packet SHALL take effect at the next packet.
REQ-013: Two states: EMPTY (no held sample) and REPEAT (held sample, repetition counter rep in 1..n_act).
REQ-014: EMPTY: i_tready=1, o_tvalid=0; accepting a beat SHALL load data/tlast into the holding register, set rep=1, go to REPEAT.
REQ-015: REPEAT: o_tvalid=1; on o_tvalid&o_tready with rep<n_act, rep SHALL increment; with rep>=n_act (last repetition), the held sample is retired.
REQ-016: i_tready SHALL be 1 in EMPTY, or in REPEAT when rep>=n_act and o_tready=1; i_tready SHALL be a function of state, rep, n_act and o_tready only, not of i_tvalid.
REQ-017: On last-repetition retire with i_tvalid=1, the new beat SHALL load same cycle (stay REPEAT, rep=1); with i_tvalid=0, go to EMPTY. Throughput SHALL be one output beat per cycle under continuous valid/ready, including n_act<=1.
REQ-018: Latency SHALL be one cycle: o_tvalid rises the cycle after the first input acceptance into EMPTY.
REQ-019: o_tdata SHALL equal the held sample for rep=1; for rep>1 it SHALL equal the held sample if zs_act=0, else all zeros.
REQ-020: o_tlast SHALL be asserted only when rep>=n_act and the held sample carried i_tlast; an L-beat input packet SHALL yield an L*max(n_act,1)-beat output packet.
REQ-021: Output signals SHALL remain stable while o_tvalid=1 and o_tready=0.
REQ-022: rep comparison SHALL use >= so n_act of 0 or 1 ends on rep=1; rep SHALL never exceed MAX_N or wrap.

Reset
REQ-023: With reset_n=0 at a clock edge: state=EMPTY, rep=1, n_act=1, zs_act=0, start-of-packet flag=1, holding register=0.
REQ-024: During and after reset: o_tvalid=0, o_tlast=0, o_tdata=0; i_tready SHALL be 0 while reset_n=0 and 1 on the first cycle after release.
REQ-025: Reset mid-repetition SHALL discard the held sample and remaining repetitions; no partial packet is resumed.

Verification
REQ-026: n=1, continuous valid/ready, 8-beat packet 1..8 -> output 1..8 back-to-back, o_tlast only on 8, one cycle latency.
REQ-027: n=3, zero_stuff=0, packet {A,B} with tlast on B -> A,A,A,B,B,B, o_tlast only on final B; i_tready low for 2 of every 3 cycles.
REQ-028: n=4, zero_stuff=1, sample 0x1234 tlast=1 -> 0x1234,0,0,0, o_tlast on 4th beat.
REQ-029: n=2, random o_tready backpressure and random i_tvalid gaps -> no loss/duplication beyond n, outputs stable while stalled, count = 2x inputs.
REQ-030: n changed 2->5 mid-packet -> current packet keeps factor 2; next packet uses 5.
REQ-031: reset_n pulsed low during third repetition at n=4 -> o_tvalid=0 next cycle; next input packet output is clean with n_act re-latched.
